// File: rtl/ddram_arb_pkg.sv
// Shared types and widths for the two-client DDR arbiter.
package ddram_arb_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_RD_CMD,
        S_RD_DATA
    } arb_state_t;

    typedef logic client_idx_t;

endpackage

// File: rtl/ddram_beat_counter.sv
// Burst beat counter: latches the burst length at grant, counts accepted beats,
// flags the final beat. A zero length is treated as a single beat.
module ddram_beat_counter #(
    parameter int BURST_W = 8
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               load,
    input  logic [BURST_W-1:0] burstcnt,
    input  logic               inc,
    output logic               last
);

    logic [BURST_W-1:0] len;
    logic [BURST_W-1:0] cnt;
    logic [BURST_W-1:0] cnt_inc;

    assign cnt_inc = cnt + BURST_W'(1);
    assign last    = (cnt_inc == len);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cnt <= '0;
            len <= BURST_W'(1);
        end else if (load) begin
            cnt <= '0;
            len <= (burstcnt == '0) ? BURST_W'(1) : burstcnt;
        end else if (inc) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/ddram_arbiter.sv
// Two-client Avalon-style DDR arbiter (client 0 = GPU, client 1 = loader).
//   state     | meaning
//   S_IDLE    | no owner, all clients stalled, arbitrate pending requests
//   S_WRITE   | owner's write burst passed through until the last beat
//   S_RD_CMD  | owner's read command presented until memory accepts it
//   S_RD_DATA | read data beats routed to the owner until the last beat
module ddram_arbiter
    import ddram_arb_pkg::*;
#(
    parameter int FAIR    = 1,
    parameter int BURST_W = 8
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic [ADDR_W-1:0]  c0_addr,
    input  logic [BURST_W-1:0] c0_burstcnt,
    input  logic               c0_rd,
    input  logic               c0_we,
    input  logic [DATA_W-1:0]  c0_din,
    input  logic [BE_W-1:0]    c0_be,
    output logic               c0_busy,
    output logic [DATA_W-1:0]  c0_dout,
    output logic               c0_dout_ready,
    input  logic [ADDR_W-1:0]  c1_addr,
    input  logic [BURST_W-1:0] c1_burstcnt,
    input  logic               c1_rd,
    input  logic               c1_we,
    input  logic [DATA_W-1:0]  c1_din,
    input  logic [BE_W-1:0]    c1_be,
    output logic               c1_busy,
    output logic [DATA_W-1:0]  c1_dout,
    output logic               c1_dout_ready,
    input  logic               mem_busy,
    input  logic [DATA_W-1:0]  mem_dout,
    input  logic               mem_dout_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BURST_W-1:0] mem_burstcnt,
    output logic               mem_rd,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_din,
    output logic [BE_W-1:0]    mem_be
);

    arb_state_t  state, state_nxt;
    client_idx_t own, lg, grant;
    logic        req0, req1;
    logic        load, inc, last;
    logic        in_burst;
    logic        own_rd, own_we, sel_we;
    logic [BURST_W-1:0] sel_burstcnt;

    assign req0 = c0_rd | c0_we;
    assign req1 = c1_rd | c1_we;

    // Contention goes to the client that did not win last time when fair.
    assign grant = (req0 && req1) ? ((FAIR != 0) ? ~lg : 1'b0) : req1;

    assign sel_we       = grant ? c1_we : c0_we;
    assign sel_burstcnt = grant ? c1_burstcnt : c0_burstcnt;

    assign own_rd       = own ? c1_rd : c0_rd;
    assign own_we       = own ? c1_we : c0_we;
    assign mem_addr     = own ? c1_addr : c0_addr;
    assign mem_burstcnt = own ? c1_burstcnt : c0_burstcnt;
    assign mem_din      = own ? c1_din : c0_din;
    assign mem_be       = own ? c1_be : c0_be;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        inc       = 1'b0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    load      = 1'b1;
                    state_nxt = sel_we ? S_WRITE : S_RD_CMD;
                end
            end
            S_WRITE: begin
                mem_we = own_we;
                inc    = own_we & ~mem_busy;
                if (inc && last) state_nxt = S_IDLE;
            end
            S_RD_CMD: begin
                mem_rd = own_rd;
                if (own_rd && !mem_busy) state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                inc = mem_dout_ready;
                if (inc && last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= S_IDLE;
            own   <= 1'b0;
            lg    <= 1'b1;
        end else begin
            state <= state_nxt;
            if (load) begin
                own <= grant;
                lg  <= grant;
            end
        end
    end

    assign in_burst      = (state != S_IDLE);
    assign c0_busy       = (in_burst && !own) ? mem_busy : 1'b1;
    assign c1_busy       = (in_burst &&  own) ? mem_busy : 1'b1;
    assign c0_dout       = mem_dout;
    assign c1_dout       = mem_dout;
    assign c0_dout_ready = (state == S_RD_DATA) && !own && mem_dout_ready;
    assign c1_dout_ready = (state == S_RD_DATA) &&  own && mem_dout_ready;

    ddram_beat_counter #(
        .BURST_W (BURST_W)
    ) u_beat_cnt (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .load     (load),
        .burstcnt (sel_burstcnt),
        .inc      (inc),
        .last     (last)
    );

endmodule

// File: tb/tb_ddram_arbiter.sv
// Bench for ddram_arbiter: directed timing scenarios plus randomized
// single-client transactions checked through an expected-event queue.
module tb_ddram_arbiter;

    localparam int K_W = 1;
    localparam int K_R = 2;
    localparam int K_D = 3;

    typedef struct {
        int          kind;
        logic        cl;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } ev_t;

    logic        i_clk, i_nrst;
    logic [28:0] c0_addr, c1_addr;
    logic [7:0]  c0_burstcnt, c1_burstcnt;
    logic        c0_rd, c0_we, c1_rd, c1_we;
    logic [63:0] c0_din, c1_din;
    logic [7:0]  c0_be, c1_be;
    logic        c0_busy, c1_busy, c0_dout_ready, c1_dout_ready;
    logic [63:0] c0_dout, c1_dout;
    logic        mem_busy, mem_dout_ready;
    logic [63:0] mem_dout;
    logic [28:0] mem_addr;
    logic [7:0]  mem_burstcnt;
    logic        mem_rd, mem_we;
    logic [63:0] mem_din;
    logic [7:0]  mem_be;

    logic        fp_c0_busy, fp_c1_busy, fp_c0_dout_ready, fp_c1_dout_ready;
    logic [63:0] fp_c0_dout, fp_c1_dout;
    logic [28:0] fp_mem_addr;
    logic [7:0]  fp_mem_burstcnt;
    logic        fp_mem_rd, fp_mem_we;
    logic [63:0] fp_mem_din;
    logic [7:0]  fp_mem_be;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 0;
    ev_t exp_q[$];

    ddram_arbiter #(.FAIR(1), .BURST_W(8)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .c0_addr(c0_addr), .c0_burstcnt(c0_burstcnt), .c0_rd(c0_rd), .c0_we(c0_we),
        .c0_din(c0_din), .c0_be(c0_be), .c0_busy(c0_busy), .c0_dout(c0_dout),
        .c0_dout_ready(c0_dout_ready),
        .c1_addr(c1_addr), .c1_burstcnt(c1_burstcnt), .c1_rd(c1_rd), .c1_we(c1_we),
        .c1_din(c1_din), .c1_be(c1_be), .c1_busy(c1_busy), .c1_dout(c1_dout),
        .c1_dout_ready(c1_dout_ready),
        .mem_busy(mem_busy), .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready),
        .mem_addr(mem_addr), .mem_burstcnt(mem_burstcnt), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_din(mem_din), .mem_be(mem_be)
    );

    ddram_arbiter #(.FAIR(0), .BURST_W(8)) dut_fp (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .c0_addr(c0_addr), .c0_burstcnt(c0_burstcnt), .c0_rd(c0_rd), .c0_we(c0_we),
        .c0_din(c0_din), .c0_be(c0_be), .c0_busy(fp_c0_busy), .c0_dout(fp_c0_dout),
        .c0_dout_ready(fp_c0_dout_ready),
        .c1_addr(c1_addr), .c1_burstcnt(c1_burstcnt), .c1_rd(c1_rd), .c1_we(c1_we),
        .c1_din(c1_din), .c1_be(c1_be), .c1_busy(fp_c1_busy), .c1_dout(fp_c1_dout),
        .c1_dout_ready(fp_c1_dout_ready),
        .mem_busy(mem_busy), .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready),
        .mem_addr(fp_mem_addr), .mem_burstcnt(fp_mem_burstcnt), .mem_rd(fp_mem_rd),
        .mem_we(fp_mem_we), .mem_din(fp_mem_din), .mem_be(fp_mem_be)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_client(input bit c, input logic rd, input logic we, input logic [28:0] a,
                              input logic [7:0] bc, input logic [63:0] din, input logic [7:0] be);
        if (!c) begin
            c0_rd = rd; c0_we = we; c0_addr = a; c0_burstcnt = bc; c0_din = din; c0_be = be;
        end else begin
            c1_rd = rd; c1_we = we; c1_addr = a; c1_burstcnt = bc; c1_din = din; c1_be = be;
        end
    endtask

    task automatic clear_clients();
        set_client(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        set_client(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        i_nrst = 1'b0;
        repeat (2) tick();
        i_nrst = 1'b1;
        tick();
    endtask

    task automatic sb_check(input int kind, input logic cl, input logic [63:0] a,
                            input logic [63:0] d, input logic [7:0] be);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected_event", 64'(kind), 64'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("sb_kind", 64'(kind), 64'(e.kind));
        chk("sb_client", 64'(cl), 64'(e.cl));
        chk("sb_addr", a, e.a);
        chk("sb_data", d, e.d);
        chk("sb_be", 64'(be), 64'(e.be));
    endtask

    // Monitor: every accepted memory strobe or client read beat pops one expected event.
    always @(negedge i_clk) begin
        if (i_nrst && mon_en) begin
            if (mem_we && !mem_busy)
                sb_check(K_W, c0_busy, 64'(mem_addr), mem_din, mem_be);
            if (mem_rd && !mem_busy)
                sb_check(K_R, c0_busy, 64'(mem_addr), 64'(mem_burstcnt), 8'd0);
            if (c0_dout_ready || c1_dout_ready) begin
                chk("dout_onehot", 64'(c0_dout_ready & c1_dout_ready), 64'd0);
                sb_check(K_D, c1_dout_ready, 64'd0, c1_dout_ready ? c1_dout : c0_dout, 8'd0);
            end
        end
    end

    // One complete transaction from client c; expected memory-side events are queued first.
    task automatic do_txn(input bit c, input bit wr, input logic [28:0] addr, input logic [7:0] bc);
        int          nb, beat, guard;
        logic [63:0] d[$];
        logic [7:0]  be;
        logic [63:0] rdat;
        bit          acc;
        ev_t         e;
        nb = (bc == 0) ? 1 : int'(bc);
        be = 8'($urandom);
        for (int i = 0; i < nb; i++) d.push_back({$urandom, $urandom});
        if (wr) begin
            for (int i = 0; i < nb; i++) begin
                e = '{K_W, c, 64'(addr), d[i], be};
                exp_q.push_back(e);
            end
        end else begin
            e = '{K_R, c, 64'(addr), 64'(bc), 8'd0};
            exp_q.push_back(e);
        end
        beat  = 0;
        guard = 0;
        while (beat < (wr ? nb : 1) && guard < 200) begin
            mem_busy = ($urandom_range(0, 3) == 0);
            set_client(c, wr ? 1'($urandom) : 1'b1, wr, addr, bc, d[beat < nb ? beat : 0], be);
            #1;
            acc = !(c ? c1_busy : c0_busy);
            tick();
            if (acc) beat++;
            guard++;
        end
        if (guard >= 200) chk("txn_timeout", 64'd1, 64'd0);
        set_client(c, 1'b0, 1'b0, addr, bc, '0, '0);
        mem_busy = 1'b0;
        if (!wr) begin
            for (int i = 0; i < nb; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                rdat = {$urandom, $urandom};
                e = '{K_D, c, 64'd0, rdat, 8'd0};
                exp_q.push_back(e);
                mem_dout       = rdat;
                mem_dout_ready = 1'b1;
                tick();
                mem_dout_ready = 1'b0;
            end
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] pat;
        logic [3:0] gseq, fseq;
        int         gn, fn;

        // reset values with activity present on every input
        i_nrst = 1'b0;
        clear_clients();
        c0_we = 1'b1; c1_rd = 1'b1;
        mem_busy = 1'b0; mem_dout = 64'h1234; mem_dout_ready = 1'b1;
        #2;
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_busy", 64'({c0_busy, c1_busy}), 64'b11);
        chk("rst_dout_ready", 64'({c0_dout_ready, c1_dout_ready}), 64'b00);
        clear_clients();
        mem_dout_ready = 1'b0;
        repeat (2) tick();
        i_nrst = 1'b1;
        tick();

        // c0 write, 4 beats, no stall
        set_client(1'b0, 1'b0, 1'b1, 29'h0123456, 8'd4, 64'hA5A5_0000_1111_2222, 8'hF0);
        #1;
        chk("wr4_req_cycle_we", 64'(mem_we), 64'd0);
        pat = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) c0_we = 1'b0;
            #1;
            pat = {pat[4:0], mem_we};
            if (k == 1) begin
                chk("wr4_addr", 64'(mem_addr), 64'h0123456);
                chk("wr4_burstcnt", 64'(mem_burstcnt), 64'd4);
                chk("wr4_busy", 64'({c0_busy, c1_busy}), 64'b01);
                chk("wr4_be", 64'(mem_be), 64'hF0);
            end
        end
        chk("wr4_we_pattern", 64'(pat), 64'b111100);

        // c1 read, 2 beats, command stalled 3 cycles
        mem_busy = 1'b1;
        set_client(1'b1, 1'b1, 1'b0, 29'h1ABCDEF, 8'd2, '0, '0);
        pat = '0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) mem_busy = 1'b0;
            if (k == 5) c1_rd = 1'b0;
            #1;
            pat = {pat[4:0], mem_rd};
            if (k == 2) chk("rd2_busy_stalled", 64'({c0_busy, c1_busy}), 64'b11);
        end
        chk("rd2_rd_pattern", 64'(pat[4:0]), 64'b11110);
        tick();
        mem_dout = 64'hDEAD_BEEF_0000_0001; mem_dout_ready = 1'b1;
        #1;
        chk("rd2_beat1_route", 64'({c0_dout_ready, c1_dout_ready}), 64'b01);
        chk("rd2_beat1_c1_dout", c1_dout, 64'hDEAD_BEEF_0000_0001);
        chk("rd2_beat1_c0_dout", c0_dout, 64'hDEAD_BEEF_0000_0001);
        tick();
        mem_dout_ready = 1'b0;
        #1;
        chk("rd2_gap_route", 64'({c0_dout_ready, c1_dout_ready}), 64'b00);
        tick();
        mem_dout = 64'hDEAD_BEEF_0000_0002; mem_dout_ready = 1'b1;
        #1;
        chk("rd2_beat2_route", 64'({c0_dout_ready, c1_dout_ready}), 64'b01);
        tick();
        mem_dout_ready = 1'b0;
        #1;
        chk("rd2_back_idle_busy", 64'({c0_busy, c1_busy}), 64'b11);

        // zero burst count is one beat
        set_client(1'b0, 1'b0, 1'b1, 29'h0000040, 8'd0, 64'h77, 8'hFF);
        pat = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) c0_we = 1'b0;
            #1;
            pat = {pat[4:0], mem_we};
        end
        chk("wr0_we_pattern", 64'(pat[3:0]), 64'b1000);

        // stray read strobe while idle
        tick();
        mem_dout_ready = 1'b1;
        #1;
        chk("stray_dout_ready", 64'({c0_dout_ready, c1_dout_ready}), 64'b00);
        tick();
        mem_dout_ready = 1'b0;

        // contention with 1-beat writes: fair alternates, fixed priority keeps client 0
        do_reset();
        set_client(1'b0, 1'b0, 1'b1, 29'h100, 8'd1, 64'h0, 8'hFF);
        set_client(1'b1, 1'b0, 1'b1, 29'h200, 8'd1, 64'h1, 8'hFF);
        mem_busy = 1'b0;
        gseq = '0; fseq = '0; gn = 0; fn = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            if (mem_we) begin gseq = {gseq[2:0], c0_busy}; gn++; end
            if (fp_mem_we) begin fseq = {fseq[2:0], fp_c0_busy}; fn++; end
        end
        clear_clients();
        chk("fair_grant_count", 64'(gn), 64'd4);
        chk("fair_grant_order", 64'(gseq), 64'b0101);
        chk("fixed_grant_count", 64'(fn), 64'd4);
        chk("fixed_grant_order", 64'(fseq), 64'b0000);
        repeat (2) tick();

        // reset in the middle of an 8-beat read
        do_reset();
        set_client(1'b1, 1'b1, 1'b0, 29'h0ABCDE0, 8'd8, '0, '0);
        mem_busy = 1'b0;
        #1;
        chk("rst_mid_req_cycle", 64'(mem_rd), 64'd0);
        tick();
        #1;
        chk("rst_mid_grant_rd", 64'(mem_rd), 64'd1);
        tick();
        c1_rd = 1'b0; mem_dout = 64'hAA; mem_dout_ready = 1'b1;
        #1;
        chk("rst_mid_beat1", 64'(c1_dout_ready), 64'd1);
        tick();
        mem_dout = 64'hBB;
        tick();
        i_nrst = 1'b0;
        #1;
        chk("rst_mid_strobes", 64'({mem_rd, mem_we}), 64'b00);
        chk("rst_mid_busy", 64'({c0_busy, c1_busy}), 64'b11);
        chk("rst_mid_dout_ready", 64'({c0_dout_ready, c1_dout_ready}), 64'b00);
        tick();
        mem_dout_ready = 1'b0;
        i_nrst = 1'b1;
        tick();
        set_client(1'b1, 1'b1, 1'b0, 29'h0000123, 8'd1, '0, '0);
        #1;
        chk("rst_recover_req_cycle", 64'(mem_rd), 64'd0);
        tick();
        #1;
        chk("rst_recover_grant_rd", 64'(mem_rd), 64'd1);
        chk("rst_recover_busy", 64'({c0_busy, c1_busy}), 64'b10);
        chk("rst_recover_addr", 64'(mem_addr), 64'h123);
        tick();
        c1_rd = 1'b0; mem_dout = 64'hCC; mem_dout_ready = 1'b1;
        #1;
        chk("rst_recover_beat", 64'({c0_dout_ready, c1_dout_ready}), 64'b01);
        tick();
        mem_dout_ready = 1'b0;
        #1;
        chk("rst_recover_idle", 64'({c0_busy, c1_busy}), 64'b11);
        tick();

        // randomized serialized transactions through the scoreboard
        mon_en = 1'b1;
        for (int t = 0; t < 40; t++)
            do_txn(1'($urandom), 1'($urandom), 29'($urandom), 8'($urandom_range(0, 5)));
        repeat (3) tick();
        mon_en = 1'b0;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
